// File: rtl/pool_window_addr_gen.sv
// Read-address generator for max-pool: walks a POOL x POOL window over a ROWS x COLS map
// with a configurable stride, for each stacked channel, under a valid/ready handshake.
module pool_window_addr_gen #(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned ROWS     = 24,
    parameter int unsigned COLS     = 24,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned POOL     = 2,
    parameter int unsigned STRIDE   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    output logic              win_first,
    output logic              win_last,
    output logic              pass_last,
    output logic              busy,
    output logic              done
);
    localparam int unsigned OUT_R = (ROWS - POOL) / STRIDE + 1;
    localparam int unsigned OUT_C = (COLS - POOL) / STRIDE + 1;
    localparam int unsigned PW    = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int unsigned RW    = (OUT_R > 1) ? $clog2(OUT_R) : 1;
    localparam int unsigned CW    = (OUT_C > 1) ? $clog2(OUT_C) : 1;
    localparam int unsigned HW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(POOL - 1);
    localparam logic [RW-1:0] R_MAX = RW'(OUT_R - 1);
    localparam logic [CW-1:0] C_MAX = CW'(OUT_C - 1);
    localparam logic [HW-1:0] H_MAX = HW'(CHANNELS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic [PW-1:0]     pc_q, pc_d, pr_q, pr_d;
    logic [CW-1:0]     oc_q, oc_d;
    logic [RW-1:0]     orow_q, orow_d;
    logic [HW-1:0]     ch_q, ch_d;
    logic              valid_q, valid_d, first_q, first_d, last_q, last_d;
    logic              plast_q, plast_d, busy_q, busy_d, done_q, done_d;
    logic              load;
    logic [31:0]       offset;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        pc_d    = pc_q;
        pr_d    = pr_q;
        oc_d    = oc_q;
        orow_d  = orow_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        first_d = first_q;
        last_d  = last_q;
        plast_d = plast_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base_addr;
                    pc_d    = '0;
                    pr_d    = '0;
                    oc_d    = '0;
                    orow_d  = '0;
                    ch_d    = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                // addr_valid is always high in StRun, so out_ready alone marks a handshake
                if (out_ready) begin
                    if (plast_q) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        first_d = 1'b0;
                        last_d  = 1'b0;
                        plast_d = 1'b0;
                        state_d = StDone;
                    end else begin
                        load = 1'b1;
                        if (pc_q != P_MAX) begin
                            pc_d = pc_q + 1'b1;
                        end else begin
                            pc_d = '0;
                            if (pr_q != P_MAX) begin
                                pr_d = pr_q + 1'b1;
                            end else begin
                                pr_d = '0;
                                if (oc_q != C_MAX) begin
                                    oc_d = oc_q + 1'b1;
                                end else begin
                                    oc_d = '0;
                                    if (orow_q != R_MAX) begin
                                        orow_d = orow_q + 1'b1;
                                    end else begin
                                        orow_d = '0;
                                        ch_d   = ch_q + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        offset = 32'(ch_d) * (ROWS * COLS)
               + (32'(orow_d) * STRIDE + 32'(pr_d)) * COLS
               + 32'(oc_d) * STRIDE + 32'(pc_d);
        addr_d = load ? base_d + ADDR_W'(offset) : addr_q;
        if (load) begin
            first_d = (pr_d == '0) && (pc_d == '0);
            last_d  = (pr_d == P_MAX) && (pc_d == P_MAX);
            plast_d = (pr_d == P_MAX) && (pc_d == P_MAX) && (oc_d == C_MAX)
                   && (orow_d == R_MAX) && (ch_d == H_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            base_q  <= '0;
            addr_q  <= '0;
            pc_q    <= '0;
            pr_q    <= '0;
            oc_q    <= '0;
            orow_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            plast_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            pr_q    <= pr_d;
            oc_q    <= oc_d;
            orow_q  <= orow_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            plast_q <= plast_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign addr_out   = addr_q;
    assign addr_valid = valid_q;
    assign win_first  = first_q;
    assign win_last   = last_q;
    assign pass_last  = plast_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_pool_window_addr_gen.sv
// Bench for pool_window_addr_gen: four configurations checked against an index-decomposition
// model of the window walk, with random backpressure and stray start pulses.
module tb_pool_window_addr_gen;
    localparam int N = 4;
    int cfg_aw     [N] = '{8, 20, 20, 12};
    int cfg_rows   [N] = '{4, 4, 4, 6};
    int cfg_cols   [N] = '{4, 4, 4, 5};
    int cfg_ch     [N] = '{1, 1, 2, 3};
    int cfg_pool   [N] = '{2, 2, 2, 3};
    int cfg_stride [N] = '{2, 1, 2, 2};

    logic        clk = 1'b0;
    logic        reset;
    logic        start     [N];
    logic        out_ready [N];
    logic [19:0] base_i    [N];
    logic [19:0] addr_o    [N];
    logic        valid_o [N], first_o [N], last_o [N], plast_o [N], busy_o [N], done_o [N];
    logic [7:0]  addr_a;
    logic [11:0] addr_w;

    always #5 clk = ~clk;

    assign addr_o[0] = {12'd0, addr_a};
    assign addr_o[3] = {8'd0, addr_w};

    pool_window_addr_gen #(.ADDR_W(8), .ROWS(4), .COLS(4), .CHANNELS(1), .POOL(2), .STRIDE(2))
    u_dut_a (.clk(clk), .reset(reset), .start(start[0]), .base_addr(base_i[0][7:0]),
        .out_ready(out_ready[0]), .addr_out(addr_a), .addr_valid(valid_o[0]),
        .win_first(first_o[0]), .win_last(last_o[0]), .pass_last(plast_o[0]),
        .busy(busy_o[0]), .done(done_o[0]));

    pool_window_addr_gen #(.ADDR_W(20), .ROWS(4), .COLS(4), .CHANNELS(1), .POOL(2), .STRIDE(1))
    u_dut_b (.clk(clk), .reset(reset), .start(start[1]), .base_addr(base_i[1]),
        .out_ready(out_ready[1]), .addr_out(addr_o[1]), .addr_valid(valid_o[1]),
        .win_first(first_o[1]), .win_last(last_o[1]), .pass_last(plast_o[1]),
        .busy(busy_o[1]), .done(done_o[1]));

    pool_window_addr_gen #(.ADDR_W(20), .ROWS(4), .COLS(4), .CHANNELS(2), .POOL(2), .STRIDE(2))
    u_dut_c (.clk(clk), .reset(reset), .start(start[2]), .base_addr(base_i[2]),
        .out_ready(out_ready[2]), .addr_out(addr_o[2]), .addr_valid(valid_o[2]),
        .win_first(first_o[2]), .win_last(last_o[2]), .pass_last(plast_o[2]),
        .busy(busy_o[2]), .done(done_o[2]));

    pool_window_addr_gen #(.ADDR_W(12), .ROWS(6), .COLS(5), .CHANNELS(3), .POOL(3), .STRIDE(2))
    u_dut_d (.clk(clk), .reset(reset), .start(start[3]), .base_addr(base_i[3][11:0]),
        .out_ready(out_ready[3]), .addr_out(addr_w), .addr_valid(valid_o[3]),
        .win_first(first_o[3]), .win_last(last_o[3]), .pass_last(plast_o[3]),
        .busy(busy_o[3]), .done(done_o[3]));

    int          checks = 0;
    int          failures = 0;
    int unsigned exp_addr [$];
    bit          exp_first [$], exp_last [$], exp_plast [$];
    int unsigned got_addr [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned mask_of(input int d);
        return (32'd1 << cfg_aw[d]) - 32'd1;
    endfunction

    // Element k of the pass is decomposed into (channel, window row, window col, pr, pc).
    task automatic build(input int d, input int unsigned base);
        int unsigned rows = cfg_rows[d], cols = cfg_cols[d], pool = cfg_pool[d];
        int unsigned stride = cfg_stride[d];
        int unsigned outr = (rows - pool) / stride + 1;
        int unsigned outc = (cols - pool) / stride + 1;
        int unsigned pp = pool * pool;
        int unsigned total = cfg_ch[d] * outr * outc * pp;
        exp_addr.delete(); exp_first.delete(); exp_last.delete(); exp_plast.delete();
        for (int unsigned k = 0; k < total; k++) begin
            int unsigned win = k / pp, e = k % pp;
            int unsigned pr = e / pool, pc = e % pool;
            int unsigned oc = win % outc, orow = (win / outc) % outr, c = win / (outc * outr);
            exp_addr.push_back((base + c * rows * cols + (orow * stride + pr) * cols
                                + oc * stride + pc) & mask_of(d));
            exp_first.push_back(e == 0);
            exp_last.push_back(e == pp - 1);
            exp_plast.push_back(k == total - 1);
        end
    endtask

    task automatic run_pass(input int d, input int unsigned base, input bit rnd,
                            input int stall_idx, input bit poke);
        int n = 0, cyc = 0, stall = 0, total;
        bit rdy;
        build(d, base);
        total = exp_addr.size();
        got_addr.delete();
        base_i[d] = 20'(base);
        start[d] = 1'b1;
        out_ready[d] = 1'b0;
        step();
        start[d] = 1'b0;
        while (n < total && cyc < 8 * total + 16) begin
            cyc++;
            check("valid", valid_o[d], 1);
            check("busy", busy_o[d], 1);
            check("addr", addr_o[d] & mask_of(d), exp_addr[n]);
            check("win_first", first_o[d], exp_first[n]);
            check("win_last", last_o[d], exp_last[n]);
            check("pass_last", plast_o[d], exp_plast[n]);
            if (n == stall_idx && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            out_ready[d] = rdy;
            if (poke) begin
                start[d] = 1'($urandom_range(0, 1));
                base_i[d] = 20'($urandom);
            end
            if (rdy) begin
                got_addr.push_back(addr_o[d] & mask_of(d));
                n++;
            end
            step();
        end
        start[d] = 1'b0;
        check("handshakes", n, total);
        check("valid_end", valid_o[d], 0);
        check("done", done_o[d], 1);
        check("busy_end", busy_o[d], 0);
        out_ready[d] = 1'($urandom_range(0, 1));
        if (poke) start[d] = 1'b1;
        step();
        start[d] = 1'b0;
        check("done_pulse", done_o[d], 0);
        check("busy_idle", busy_o[d], 0);
        check("valid_idle", valid_o[d], 0);
    endtask

    task automatic check_zero(input int d, input string tag);
        check({tag, "_addr"}, addr_o[d] & mask_of(d), 0);
        check({tag, "_valid"}, valid_o[d], 0);
        check({tag, "_first"}, first_o[d], 0);
        check({tag, "_last"}, last_o[d], 0);
        check({tag, "_plast"}, plast_o[d], 0);
        check({tag, "_busy"}, busy_o[d], 0);
        check({tag, "_done"}, done_o[d], 0);
    endtask

    int unsigned t1 [16] = '{100, 101, 104, 105, 102, 103, 106, 107,
                             108, 109, 112, 113, 110, 111, 114, 115};
    int unsigned t_b2 [4] = '{101, 102, 105, 106};
    int unsigned t_bl [4] = '{110, 111, 114, 115};
    int unsigned t_wr [8] = '{254, 255, 2, 3, 0, 1, 4, 5};

    initial begin
        reset = 1'b0;
        for (int d = 0; d < N; d++) begin
            start[d] = 1'b0;
            out_ready[d] = 1'b0;
            base_i[d] = '0;
        end
        repeat (3) step();
        for (int d = 0; d < N; d++) check_zero(d, "reset");
        reset = 1'b1;
        step();

        run_pass(0, 100, 1'b0, -1, 1'b0);
        for (int i = 0; i < 16; i++) check("seq_s2", got_addr[i], t1[i]);

        run_pass(0, 100, 1'b0, 2, 1'b0);

        run_pass(1, 100, 1'b0, -1, 1'b0);
        check("s1_count", got_addr.size(), 36);
        for (int i = 0; i < 4; i++) check("s1_win2", got_addr[4 + i], t_b2[i]);
        check("s1_win4", got_addr[12], 104);
        for (int i = 0; i < 4; i++) check("s1_last_win", got_addr[32 + i], t_bl[i]);

        run_pass(2, 0, 1'b0, -1, 1'b0);
        check("ch_count", got_addr.size(), 32);
        check("ch2_first", got_addr[16], 16);
        check("ch_last", got_addr[31], 31);

        // Abort a pass after its 6th handshake.
        base_i[0] = 20'd100;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        out_ready[0] = 1'b1;
        repeat (6) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        out_ready[0] = 1'b0;
        check_zero(0, "midreset");
        run_pass(0, 200, 1'b0, -1, 1'b0);
        check("restart", got_addr[0], 200);

        run_pass(0, 254, 1'b0, -1, 1'b0);
        for (int i = 0; i < 8; i++) check("wrap", got_addr[i], t_wr[i]);

        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < N; d++) run_pass(d, $urandom_range(0, 4000), 1'b1, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
